// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer for the Tomasulo RISC-V core.
// Allocates at tail, captures CDB results, retires head, flushes on mispredict.
module reorder_buffer #(
  parameter int RoB_WIDTH = 3,
  parameter int NON_DEP   = 1 << RoB_WIDTH
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 rdy_in,
  input  logic                 issue_valid,
  output logic                 issue_ready,
  input  logic [1:0]           issue_type,
  input  logic [4:0]           issue_rd,
  input  logic [31:0]          issue_pc,
  input  logic                 issue_pred_taken,
  output logic [RoB_WIDTH-1:0] alloc_index,
  input  logic                 cdb_valid,
  input  logic [RoB_WIDTH-1:0] cdb_index,
  input  logic [31:0]          cdb_value,
  input  logic                 cdb_taken,
  input  logic [31:0]          cdb_target,
  input  logic [RoB_WIDTH-1:0] qj_index,
  input  logic [RoB_WIDTH-1:0] qk_index,
  output logic                 qj_ready,
  output logic                 qk_ready,
  output logic [31:0]          qj_value,
  output logic [31:0]          qk_value,
  output logic                 rf_update_en,
  output logic [4:0]           rf_update_reg,
  output logic [RoB_WIDTH-1:0] rf_update_index,
  output logic [31:0]          rf_update_data,
  output logic                 store_commit_en,
  output logic [RoB_WIDTH-1:0] store_commit_index,
  output logic                 flush_signal,
  output logic [31:0]          flush_pc,
  output logic                 debug_en,
  output logic [31:0]          debug_commit_id
);

  localparam int SIZE = 1 << RoB_WIDTH;
  localparam logic [RoB_WIDTH:0] FULL_CNT = NON_DEP[RoB_WIDTH:0];

  typedef enum logic [1:0] {
    T_REG    = 2'd0,
    T_BRANCH = 2'd1,
    T_STORE  = 2'd2,
    T_JALR   = 2'd3
  } rob_type_e;

  typedef struct packed {
    logic        busy;
    logic        ready;
    rob_type_e   kind;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        pred;
    logic [31:0] value;
    logic        taken;
    logic [31:0] target;
  } entry_t;

  entry_t ent [SIZE];

  logic [RoB_WIDTH-1:0] head;
  logic [RoB_WIDTH-1:0] tail;
  logic [RoB_WIDTH:0]   count;

  logic        full;
  logic        issue_go;
  logic        commit_go;
  logic        cdb_hit;
  entry_t      hd;
  logic        mispredict;
  logic [31:0] redirect;
  logic        qj_byp;
  logic        qk_byp;

  assign hd          = ent[head];
  assign full        = (count == FULL_CNT);
  assign issue_ready = !full && !flush_signal;
  assign alloc_index = tail;
  assign issue_go    = issue_valid && issue_ready;
  assign cdb_hit     = cdb_valid && ent[cdb_index].busy;
  assign commit_go   = !flush_signal && hd.busy && hd.ready;
  assign mispredict  = hd.taken != hd.pred;
  assign redirect    = hd.taken ? hd.target : hd.pc + 32'd4;

  assign qj_byp   = cdb_valid && (cdb_index == qj_index);
  assign qk_byp   = cdb_valid && (cdb_index == qk_index);
  assign qj_ready = ent[qj_index].busy && (ent[qj_index].ready || qj_byp);
  assign qk_ready = ent[qk_index].busy && (ent[qk_index].ready || qk_byp);
  assign qj_value = qj_byp ? cdb_value : ent[qj_index].value;
  assign qk_value = qk_byp ? cdb_value : ent[qk_index].value;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      for (int i = 0; i < SIZE; i++) ent[i] <= '0;
      rf_update_en <= 1'b0;
      rf_update_reg <= '0;
      rf_update_index <= '0;
      rf_update_data <= '0;
      store_commit_en <= 1'b0;
      store_commit_index <= '0;
      flush_signal <= 1'b0;
      flush_pc <= '0;
      debug_en <= 1'b0;
      debug_commit_id <= '0;
    end else if (!rdy_in) begin
      rf_update_en <= 1'b0;
      store_commit_en <= 1'b0;
      flush_signal <= 1'b0;
      debug_en <= 1'b0;
    end else begin
      rf_update_en <= 1'b0;
      store_commit_en <= 1'b0;
      flush_signal <= 1'b0;
      debug_en <= 1'b0;
      if (flush_signal) begin
        for (int i = 0; i < SIZE; i++) begin
          ent[i].busy <= 1'b0;
          ent[i].ready <= 1'b0;
        end
        head <= '0;
        tail <= '0;
        count <= '0;
      end else begin
        if (issue_go) begin
          ent[tail].busy <= 1'b1;
          ent[tail].ready <= 1'b0;
          ent[tail].kind <= rob_type_e'(issue_type);
          ent[tail].rd <= issue_rd;
          ent[tail].pc <= issue_pc;
          ent[tail].pred <= issue_pred_taken;
          tail <= tail + 1'b1;
        end
        if (cdb_hit) begin
          ent[cdb_index].ready <= 1'b1;
          ent[cdb_index].value <= cdb_value;
          ent[cdb_index].taken <= cdb_taken;
          ent[cdb_index].target <= cdb_target;
        end
        // Commit clears busy only; ready is reinitialised at allocation.
        if (commit_go) begin
          ent[head].busy <= 1'b0;
          head <= head + 1'b1;
          debug_en <= 1'b1;
          debug_commit_id <= debug_commit_id + 32'd1;
          unique case (hd.kind)
            T_REG: begin
              rf_update_en <= hd.rd != 5'd0;
              rf_update_reg <= hd.rd;
              rf_update_index <= head;
              rf_update_data <= hd.value;
            end
            T_JALR: begin
              rf_update_en <= hd.rd != 5'd0;
              rf_update_reg <= hd.rd;
              rf_update_index <= head;
              rf_update_data <= hd.value;
              flush_signal <= 1'b1;
              flush_pc <= hd.target;
            end
            T_BRANCH: begin
              if (mispredict) begin
                flush_signal <= 1'b1;
                flush_pc <= redirect;
              end
            end
            T_STORE: begin
              store_commit_en <= 1'b1;
              store_commit_index <= head;
            end
          endcase
        end
        if (issue_go && !commit_go) count <= count + 1'b1;
        else if (!issue_go && commit_go) count <= count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: commit records queued at issue,
// checked in order by a monitor as commit pulses appear.
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b1;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  logic [1:0]  issue_type = '0;
  logic [4:0]  issue_rd = '0;
  logic [31:0] issue_pc = '0;
  logic        issue_pred_taken = 1'b0;
  logic [2:0]  alloc_index;
  logic        cdb_valid = 1'b0;
  logic [2:0]  cdb_index = '0;
  logic [31:0] cdb_value = '0;
  logic        cdb_taken = 1'b0;
  logic [31:0] cdb_target = '0;
  logic [2:0]  qj_index = '0;
  logic [2:0]  qk_index = '0;
  logic        qj_ready, qk_ready;
  logic [31:0] qj_value, qk_value;
  logic        rf_update_en;
  logic [4:0]  rf_update_reg;
  logic [2:0]  rf_update_index;
  logic [31:0] rf_update_data;
  logic        store_commit_en;
  logic [2:0]  store_commit_index;
  logic        flush_signal;
  logic [31:0] flush_pc;
  logic        debug_en;
  logic [31:0] debug_commit_id;

  reorder_buffer #(.RoB_WIDTH(3)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_type(issue_type), .issue_rd(issue_rd),
    .issue_pc(issue_pc), .issue_pred_taken(issue_pred_taken),
    .alloc_index(alloc_index),
    .cdb_valid(cdb_valid), .cdb_index(cdb_index),
    .cdb_value(cdb_value), .cdb_taken(cdb_taken),
    .cdb_target(cdb_target),
    .qj_index(qj_index), .qk_index(qk_index),
    .qj_ready(qj_ready), .qk_ready(qk_ready),
    .qj_value(qj_value), .qk_value(qk_value),
    .rf_update_en(rf_update_en), .rf_update_reg(rf_update_reg),
    .rf_update_index(rf_update_index),
    .rf_update_data(rf_update_data),
    .store_commit_en(store_commit_en),
    .store_commit_index(store_commit_index),
    .flush_signal(flush_signal), .flush_pc(flush_pc),
    .debug_en(debug_en), .debug_commit_id(debug_commit_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rf;
    logic [4:0]  rg;
    logic [2:0]  ix;
    logic [31:0] dat;
    logic        st;
    logic        fl;
    logic [31:0] fpc;
  } exp_t;

  exp_t        sbq[$];
  int          total = 0;
  int          bad = 0;
  int          exp_id = 0;
  logic [2:0]  tail_m = '0;
  logic [31:0] pv [8];
  logic        ptk [8];
  logic [31:0] ptg [8];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && debug_en) begin
      if (sbq.size() == 0) chk("extra_commit", 1, 0);
      else begin
        e = sbq.pop_front();
        exp_id++;
        chk("rf_en", rf_update_en, e.rf);
        if (e.rf) begin
          chk("rf_reg", rf_update_reg, e.rg);
          chk("rf_idx", rf_update_index, e.ix);
          chk("rf_data", rf_update_data, e.dat);
        end
        chk("st_en", store_commit_en, e.st);
        if (e.st) chk("st_idx", store_commit_index, e.ix);
        chk("flush", flush_signal, e.fl);
        if (e.fl) chk("flush_pc", flush_pc, e.fpc);
        chk("commit_id", debug_commit_id, exp_id);
      end
    end else if (rst_n && (rf_update_en || store_commit_en || flush_signal)) begin
      chk("stray_pulse", 1, 0);
    end
  end

  task automatic step();
    @(negedge clk);
    issue_valid = 1'b0;
    cdb_valid = 1'b0;
  endtask

  task automatic set_issue(input logic [1:0] t, input logic [4:0] rd,
                           input logic [31:0] pc, input logic pred,
                           input logic [31:0] v, input logic tk,
                           input logic [31:0] tg, input logic acc);
    exp_t e;
    issue_valid = 1'b1;
    issue_type = t;
    issue_rd = rd;
    issue_pc = pc;
    issue_pred_taken = pred;
    #1;
    chk("issue_ready", issue_ready, acc);
    if (acc) begin
      chk("alloc_index", alloc_index, tail_m);
      e.ix = tail_m;
      e.rg = rd;
      e.dat = v;
      e.rf = (t == 2'd0 || t == 2'd3) && rd != 5'd0;
      e.st = t == 2'd2;
      e.fl = (t == 2'd3) || (t == 2'd1 && tk != pred);
      e.fpc = (t == 2'd3 || tk) ? tg : pc + 32'd4;
      pv[tail_m] = v;
      ptk[tail_m] = tk;
      ptg[tail_m] = tg;
      sbq.push_back(e);
      tail_m = tail_m + 3'd1;
    end
  endtask

  task automatic set_cdb(input logic [2:0] i);
    cdb_valid = 1'b1;
    cdb_index = i;
    cdb_value = pv[i];
    cdb_taken = ptk[i];
    cdb_target = ptg[i];
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_ready", issue_ready, 1);
    chk("rst_alloc", alloc_index, 0);
    chk("rst_rf_en", rf_update_en, 0);
    chk("rst_st_en", store_commit_en, 0);
    chk("rst_flush", flush_signal, 0);
    chk("rst_dbg", debug_en, 0);
    chk("rst_id", debug_commit_id, 0);
    sbq.delete();
    exp_id = 0;
    tail_m = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (sbq.size() == 0) break;
      step();
    end
    chk("drain_left", sbq.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    do_reset();

    // reset while entries are live and a commit pulse is high
    for (int i = 0; i < 3; i++) begin
      set_issue(2'd0, 5'(i + 1), 32'h10 + 32'(4 * i), 1'b0,
                32'h1000 + 32'(i), 1'b0, 32'h0, 1'b1);
      step();
    end
    set_cdb(3'd0);
    step();
    step();
    chk("pulse_pre_rst", rf_update_en, 1);
    #2;
    do_reset();

    // single REG commit latency
    set_issue(2'd0, 5'd5, 32'h100, 1'b0, 32'hDEAD, 1'b0, 32'h0, 1'b1);
    step();
    set_cdb(3'd0);
    step();
    chk("lat_cdb_edge", debug_en, 0);
    step();
    chk("lat_commit", rf_update_en, 1);
    chk("lat_id", debug_commit_id, 1);
    drain();
    do_reset();

    // out-of-order completion, in-order commit, bypass query
    for (int i = 0; i < 3; i++) begin
      set_issue(2'd0, 5'(10 + i), 32'h300 + 32'(4 * i), 1'b0,
                32'hA0 + 32'(i), 1'b0, 32'h0, 1'b1);
      step();
    end
    set_cdb(3'd2);
    qj_index = 3'd2;
    qk_index = 3'd1;
    #1;
    chk("qj_bypass_rdy", qj_ready, 1);
    chk("qj_bypass_val", qj_value, 32'hA2);
    chk("qk_not_rdy", qk_ready, 0);
    step();
    set_cdb(3'd1);
    step();
    chk("qk_stored_rdy", qk_ready, 1);
    chk("qk_stored_val", qk_value, 32'hA1);
    set_cdb(3'd0);
    step();
    chk("ooo_wait", debug_en, 0);
    step();
    chk("ooo_c0", debug_en, 1);
    step();
    chk("ooo_c1", debug_en, 1);
    step();
    chk("ooo_c2", debug_en, 1);
    step();
    chk("ooo_idle", debug_en, 0);
    do_reset();

    // fill, wrap, commit does not free a slot in its own cycle
    for (int i = 0; i < 8; i++) begin
      set_issue(2'd0, 5'(i + 1), 32'h400 + 32'(4 * i), 1'b0,
                32'hB0 + 32'(i), 1'b0, 32'h0, 1'b1);
      step();
    end
    #1;
    chk("full_alloc", alloc_index, 0);
    set_cdb(3'd0);
    step();
    set_issue(2'd0, 5'd20, 32'h4F0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step();
    set_issue(2'd0, 5'd21, 32'h500, 1'b0, 32'hC0, 1'b0, 32'h0, 1'b1);
    step();
    #1;
    chk("refull_ready", issue_ready, 0);
    for (int i = 1; i < 8; i++) begin
      set_cdb(3'(i));
      step();
    end
    set_cdb(3'd0);
    step();
    drain();
    do_reset();

    // branch mispredicted as not-taken
    set_issue(2'd1, 5'd0, 32'h200, 1'b0, 32'h0, 1'b1, 32'h400, 1'b1);
    step();
    set_cdb(3'd0);
    step();
    step();
    chk("mp1_flush", flush_signal, 1);
    chk("mp1_pc", flush_pc, 32'h400);
    set_issue(2'd0, 5'd3, 32'h600, 1'b0, 32'h1, 1'b0, 32'h0, 1'b0);
    step();
    chk("mp1_clear", flush_signal, 0);
    tail_m = '0;

    // branch mispredicted as taken
    set_issue(2'd1, 5'd0, 32'h200, 1'b1, 32'h0, 1'b0, 32'h400, 1'b1);
    step();
    set_cdb(3'd0);
    step();
    step();
    chk("mp2_pc", flush_pc, 32'h204);
    step();
    tail_m = '0;

    // rd=0, correct branch, store at idx3, JALR redirect
    set_issue(2'd0, 5'd0, 32'h700, 1'b0, 32'h11, 1'b0, 32'h0, 1'b1);
    step();
    set_issue(2'd0, 5'd9, 32'h704, 1'b0, 32'h22, 1'b0, 32'h0, 1'b1);
    step();
    set_issue(2'd1, 5'd0, 32'h708, 1'b1, 32'h0, 1'b1, 32'h900, 1'b1);
    step();
    set_issue(2'd2, 5'd0, 32'h70C, 1'b0, 32'h33, 1'b0, 32'h0, 1'b1);
    step();
    set_issue(2'd3, 5'd1, 32'h710, 1'b0, 32'h714, 1'b1, 32'h800, 1'b1);
    step();
    for (int i = 4; i >= 0; i--) begin
      set_cdb(3'(i));
      step();
    end
    drain();
    step();
    chk("end_ready", issue_ready, 1);
    chk("end_alloc", alloc_index, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order reorder buffer for the Tomasulo RISC-V core.
- Allocates entries for instructions issued by the Dispatcher and captures results from the CDB.
- Retires the head entry to the register file via the update interface: update_en/reg/index/data, plus flush and debug strobes.
- Detects branch/JALR mispredictions at commit and broadcasts flush with a redirect PC.

Parameters:
RoB_WIDTH, 3, index width; entry count SIZE = 1 << RoB_WIDTH
NON_DEP, 1 << RoB_WIDTH, "no dependency" code (valid bit RoB_WIDTH set)

Ports:
clk_in  in  1  clock, rising edge
rst_n_in  in  1  reset, asynchronous, active-low
rdy_in  in  1  global enable; low = hold all state
issue_valid  in  1  Dispatcher offers instruction
issue_ready  out  1  = !full && !flush_signal (combinational)
issue_type  in  2  0=REG(writes rd) 1=BRANCH 2=STORE 3=JALR
issue_rd  in  5  destination register
issue_pc  in  32  instruction PC
issue_pred_taken  in  1  predictor decision
alloc_index  out  RoB_WIDTH  tail index; valid when issue_ready
cdb_valid  in  1  result broadcast
cdb_index  in  RoB_WIDTH  producing entry
cdb_value  in  32  rd value (JALR: pc+4)
cdb_taken  in  1  actual branch outcome
cdb_target  in  32  actual branch/JALR target
qj_index, qk_index  in  RoB_WIDTH each  operand lookup
qj_ready, qk_ready  out  1 each  entry value available
qj_value, qk_value  out  32 each  entry value
rf_update_en  out  1  commit pulse to RF
rf_update_reg  out  5  committed rd
rf_update_index  out  RoB_WIDTH  committed entry index
rf_update_data  out  32  committed value
store_commit_en  out  1  pulse: head store may write memory
store_commit_index  out  RoB_WIDTH  committed store entry
flush_signal  out  1  misprediction flush pulse
flush_pc  out  32  redirect PC
debug_en  out  1  pulses with every commit
debug_commit_id  out  32  running commit count (value after this commit)

Behaviour:
- Reset (async, rst_n_in=0): head=tail=count=0; all busy/ready bits 0; every registered output 0; debug_commit_id=0.
- rdy_in=0: no state change. Pulse outputs (rf_update_en, store_commit_en, flush_signal, debug_en) drop to 0 at the next edge.
- Entry fields: busy, ready, type, rd, pc, pred_taken, value, taken, target.
- full = (count == SIZE); empty = (count == 0).
- Issue: at edge, if issue_valid && issue_ready:
  - write entry[tail] with busy=1, ready=0;
  - tail = tail+1 mod SIZE; count+1.
- Full status is sampled before the edge. A commit in the same cycle does not free a slot for that cycle's issue.
- CDB: at edge, if cdb_valid && entry[cdb_index].busy, set ready=1 and latch value/taken/target. CDB writes to non-busy entries are ignored.
- Query (combinational), with CDB bypass:
  - ready = entry.busy && (entry.ready || (cdb_valid && cdb_index==q));
  - value = cdb_value on bypass, else entry.value.
- Commit: at most one per cycle.
  - Condition: at edge, !flush_signal && entry[head].busy && entry[head].ready, using state sampled before the edge. A CDB write in cycle N therefore commits no earlier than edge N+1.
  - Action: clear busy; head+1 mod SIZE; count-1; debug_en=1; debug_commit_id+1.
  - REG: rf_update_en=1 only if rd != 0; reg/index/data driven from the entry.
  - JALR: rf_update_en as for REG (if rd != 0); also flush_signal=1, flush_pc=target.
  - BRANCH: no RF update. If taken != pred_taken: flush_signal=1, flush_pc = taken ? target : pc+4 (mod 2^32).
  - STORE: store_commit_en=1, store_commit_index=head.
- All commit outputs are registered, one-cycle pulses. Data fields hold their last value.
- Simultaneous issue+commit: count is unchanged; tail and head both advance.
- Flush: in the cycle flush_signal=1, the next edge clears all busy/ready bits and sets head=tail=count=0. Issue and CDB in that cycle are discarded (issue_ready=0). flush_signal then deasserts.
- Wrap-around: indices wrap modulo SIZE. Index SIZE-1 is followed by 0.

Test Plan:
- Reset mid-operation: with 3 entries busy, pull rst_n_in low → issue_ready=1, alloc_index=0, and all pulses 0 immediately.
- Issue REG rd=5 pc=0x100 (index 0); CDB idx0 value=0xDEAD → one cycle later rf_update_en=1, reg=5, index=0, data=0xDEAD, debug_commit_id=1.
- Out-of-order completion: issue idx0..2, CDB order 2,1,0 → commits occur in order 0,1,2 on three consecutive cycles after idx0's CDB. Query idx2 with cdb_index=2 in the same cycle → qj_ready=1 via bypass.
- Full/wrap: issue 8 entries → issue_ready=0, alloc_index=0. Commit idx0 and issue one more → new entry allocated at index 0, count stays 8.
- Mispredict: BRANCH pc=0x200 pred_taken=0, CDB taken=1 target=0x400 → flush_signal=1, flush_pc=0x400, no rf_update_en. Next cycle count=0, and a same-cycle issue is not accepted. Repeat with pred_taken=1, taken=0 → flush_pc=0x204.
- rd=0 and STORE: REG rd=0 commits with rf_update_en=0 and debug_en=1. STORE at idx3 → store_commit_en=1, store_commit_index=3.
